i2c_eeprom_target: RTL and testbench

- Parametrised, system-clocked I2C target modelling a serial EEPROM; successor to the SCL-clocked device-select/register/data model.
- Oversamples SCL/SDA on `clk`.
- Detects START, repeated START and STOP.
- Supports 1- or 2-byte word addressing, page writes with in-page wrap, and sequential/random reads.
- Sits on the I2C bus next to the controller in bench and FPGA builds.

---
 rtl/i2c_eeprom_target.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_eeprom_target.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: clk-oversampled I2C target modelling a paged serial EEPROM
module i2c_eeprom_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         ADDR_BYTES  = 1,
  parameter int         MEM_DEPTH   = 256,
  parameter int         PAGE_SIZE   = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  output logic                         busy,
  output logic                         wr_pulse,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [1:0] NAB = 2'(ADDR_BYTES);
  typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, ADDR, ACK_ADDR, WDATA, ACK_W, RDATA, ACK_R} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_p_q, sda_p_q;
  logic [7:0] sr_q, sr_d, hi_q, hi_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic rw_q, rw_d;
  logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_pulse_q, wr_pulse_d;
  logic we, match;
  logic [7:0] mem_q [MEM_DEPTH];
  logic scl_s, sda_s, rise, fall, start, stop;
  logic [7:0] rd_byte, in_byte;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign rise = scl_s & ~scl_p_q;
  assign fall = ~scl_s & scl_p_q;
  assign start = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign rd_byte = mem_q[ptr_q];
  assign in_byte = {sr_q[6:0], sda_s};
  assign match = sr_q[7:1] == DEV_ADDR;
  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  // synchronise the bus lines and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_p_q <= scl_s;
    sda_p_q <= sda_s;
  end
  // storage array, written only when a complete data byte is committed
  always_ff @(posedge clk) begin
    if (we && rst) mem_q[ptr_q] <= in_byte;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      ab_q <= '0;
      rw_q <= 1'b0;
      ptr_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      ab_q <= ab_d;
      rw_q <= rw_d;
      ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  // protocol FSM: bus conditions override bit-level activity; SDA only moves on SCL falls
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    hi_d = hi_q;
    cnt_d = cnt_q;
    ab_d = ab_q;
    rw_d = rw_q;
    ptr_d = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we = 1'b0;
    if (start) begin
      state_d = DEV;
      cnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        DEV: begin
          if (rise) begin
            sr_d = in_byte;
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            state_d = match ? ACK_DEV : IDLE;
            sda_oe_d = match;
            busy_d = match;
            rw_d = sr_q[0];
          end
        end
        ACK_DEV: begin
          if (fall) begin
            state_d = rw_q ? RDATA : ADDR;
            sr_d = rd_byte;
            sda_oe_d = rw_q & ~rd_byte[7];
            ab_d = '0;
            cnt_d = '0;
          end
        end
        ADDR: begin
          if (rise) begin
            sr_d = in_byte;
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            sda_oe_d = 1'b1;
            ab_d = ab_q + 2'd1;
            state_d = ACK_ADDR;
            if (ab_q + 2'd1 == NAB) ptr_d = AW'({hi_q, sr_q});
            else hi_d = sr_q;
          end
        end
        ACK_ADDR: begin
          if (fall) begin
            sda_oe_d = 1'b0;
            state_d = (ab_q == NAB) ? WDATA : ADDR;
          end
        end
        WDATA: begin
          if (rise) begin
            sr_d = in_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              we = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = in_byte;
              ptr_d = (ptr_q & ~PAGE_MASK) | ((ptr_q + AW'(1)) & PAGE_MASK);
            end
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            sda_oe_d = 1'b1;
            state_d = ACK_W;
          end
        end
        ACK_W: begin
          if (fall) begin
            sda_oe_d = 1'b0;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            sda_oe_d = 1'b0;
            ptr_d = ptr_q + AW'(1);
            state_d = ACK_R;
          end else if (fall) begin
            sr_d = {sr_q[6:0], 1'b0};
            sda_oe_d = ~sr_q[6];
          end
        end
        ACK_R: begin
          if (rise && sda_s) begin
            state_d = IDLE;
            sda_oe_d = 1'b0;
            busy_d = 1'b0;
          end else if (rise) begin
            cnt_d = 4'd1;
          end else if (fall && cnt_q != 4'd0) begin
            cnt_d = '0;
            sr_d = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb_i2c_eeprom_target: bus-level bench for two EEPROM targets sharing one I2C bus
module tb_i2c_eeprom_target;
  localparam int Q = 80;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic oe0, busy0, wp0, oe1, busy1, wp1, sda;
  logic [7:0] wa0, wd0, wd1;
  logic [9:0] wa1;
  int checks = 0;
  int failures = 0;
  int p [2];
  logic [7:0] mem_m [2][1024];
  logic [7:0] dq [$];
  int exp_q [$];
  int obs_q [$];
  assign sda = sda_m & ~oe0 & ~oe1;
  always #5 clk = ~clk;
  i2c_eeprom_target u0 (.clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda), .sda_oe(oe0),
    .busy(busy0), .wr_pulse(wp0), .wr_addr(wa0), .wr_data(wd0));
  i2c_eeprom_target #(.DEV_ADDR(7'h54), .ADDR_BYTES(2), .MEM_DEPTH(1024)) u1 (.clk(clk), .rst(rst),
    .scl_i(scl_m), .sda_i(sda), .sda_oe(oe1), .busy(busy1), .wr_pulse(wp1), .wr_addr(wa1), .wr_data(wd1));
  // record every committed byte as {instance, address, data}
  always @(negedge clk) begin
    if (wp0) obs_q.push_back((int'(wa0) << 8) | int'(wd0));
    if (wp1) obs_q.push_back((1 << 24) | (int'(wa1) << 8) | int'(wd1));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int dev_of(input int s);
    return s != 0 ? 'h54 : 'h50;
  endfunction
  function automatic int depth_of(input int s);
    return s != 0 ? 1024 : 256;
  endfunction
  task automatic bit_out(input logic b);
    sda_m = b;
    #Q scl_m = 1'b1;
    #(2 * Q) scl_m = 1'b0;
    #Q;
  endtask
  task automatic bit_in(output logic b);
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q b = sda;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic start();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask
  task automatic wbyte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(ack);
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] v);
    logic x;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bit_in(x);
      v = {v[6:0], x};
    end
    bit_out(nack);
  endtask
  task automatic fill(input int n);
    dq.delete();
    repeat (n) dq.push_back(8'($urandom));
  endtask
  task automatic set_addr(input int s, input int a);
    logic ack;
    start();
    wbyte(8'(dev_of(s) * 2), ack);
    chk("dev_ack", ack, 0);
    chk("busy_on", s != 0 ? busy1 : busy0, 1);
    if (s != 0) begin
      wbyte(8'(a >> 8), ack);
      chk("addr_hi_ack", ack, 0);
    end
    wbyte(8'(a), ack);
    chk("addr_lo_ack", ack, 0);
    p[s] = a % depth_of(s);
  endtask
  task automatic wr(input int s, input int a);
    logic ack;
    set_addr(s, a);
    for (int i = 0; i < dq.size(); i++) begin
      wbyte(dq[i], ack);
      chk("data_ack", ack, 0);
      mem_m[s][p[s]] = dq[i];
      exp_q.push_back((s << 24) | (p[s] << 8) | int'(dq[i]));
      p[s] = p[s] - p[s] % 8 + (p[s] + 1) % 8;
    end
    stop();
  endtask
  task automatic cur(input int s, input int n);
    logic ack;
    logic [7:0] v;
    start();
    wbyte(8'(dev_of(s) * 2 + 1), ack);
    chk("rd_dev_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, v);
      chk("rd_data", v, mem_m[s][p[s]]);
      p[s] = (p[s] + 1) % depth_of(s);
    end
    chk("rd_oe_released", s != 0 ? oe1 : oe0, 0);
    chk("rd_busy_off", s != 0 ? busy1 : busy0, 0);
    stop();
  endtask
  task automatic rd(input int s, input int a, input int n);
    set_addr(s, a);
    cur(s, n);
  endtask
  task automatic chk_wr();
    chk("wr_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk("wr_entry", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic ack;
    logic x;
    int a;
    p[0] = 0;
    p[1] = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_u0", {oe0, busy0, wp0, wa0, wd0}, 0);
    chk("rst_u1", {oe1, busy1, wp1, wa1, wd1}, 0);
    rst = 1'b1;
    #Q;
    dq.delete();
    dq.push_back(8'h5A);
    wr(0, 'h12);
    chk_wr();
    rd(0, 'h12, 1);
    start();
    wbyte(8'hA2, ack);
    chk("nack_dev", ack, 1);
    chk("nack_busy0", busy0, 0);
    chk("nack_busy1", busy1, 0);
    wbyte(8'h12, ack);
    chk("ignored_addr", ack, 1);
    wbyte(8'($urandom), ack);
    chk("ignored_data", ack, 1);
    stop();
    chk_wr();
    fill(8);
    wr(0, 'h00);
    fill(8);
    wr(0, 'h08);
    chk_wr();
    fill(4);
    wr(0, 'h06);
    chk_wr();
    rd(0, 'h00, 16);
    fill(8);
    wr(0, 'hF8);
    chk_wr();
    rd(0, 'hFE, 4);
    cur(0, 1);
    dq.delete();
    dq.push_back(8'hC3);
    wr(1, 'h0305);
    chk_wr();
    rd(1, 'hFF05, 1);
    a = int'($urandom_range(0, 65535)) & 'hFFF8;
    fill(3);
    wr(1, a);
    chk_wr();
    rd(1, a, 3);
    dq.delete();
    dq.push_back(8'h00);
    wr(0, 'h40);
    chk_wr();
    set_addr(0, 'h30);
    repeat (5) bit_out(1'($urandom));
    stop();
    chk_wr();
    set_addr(0, 'h40);
    start();
    wbyte(8'hA1, ack);
    chk("rst_rd_ack", ack, 0);
    bit_in(x);
    chk("rst_rd_msb", x, 0);
    chk("rst_rd_drive", oe0, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_u0", {oe0, busy0, wp0, wa0, wd0}, 0);
    chk("rst_mid_u1", {oe1, busy1, wp1, wa1, wd1}, 0);
    chk("rst_mid_sda", sda, 1);
    rst = 1'b1;
    p[0] = 0;
    p[1] = 0;
    #Q;
    stop();
    cur(0, 1);
    chk_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
